// File: rtl/alu_accum_pkg.sv
// Shared constants for the accumulator stage: opcodes, FSM states, widths.
package alu_accum_pkg;

    localparam int A_W   = 4;
    localparam int ACC_W = 8;

    typedef enum logic [2:0] {
        OP_ADD5    = 3'b000,
        OP_ADD     = 3'b001,
        OP_XOR_OR  = 3'b010,
        OP_ANY     = 3'b011,
        OP_ALL     = 3'b100,
        OP_INV_CAT = 3'b101,
        OP_SHL     = 3'b110,
        OP_MUL     = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_accumulator_seg7_decoder.sv
// Hex nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module seg7_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Standard 0-F glyphs, lower-case b and d so they differ from 8 and 0.
    always_comb begin
        case (nibble)
            4'h0:    seg_n = 7'b1000000;
            4'h1:    seg_n = 7'b1111001;
            4'h2:    seg_n = 7'b0100100;
            4'h3:    seg_n = 7'b0110000;
            4'h4:    seg_n = 7'b0011001;
            4'h5:    seg_n = 7'b0010010;
            4'h6:    seg_n = 7'b0000010;
            4'h7:    seg_n = 7'b1111000;
            4'h8:    seg_n = 7'b0000000;
            4'h9:    seg_n = 7'b0010000;
            4'hA:    seg_n = 7'b0001000;
            4'hB:    seg_n = 7'b0000011;
            4'hC:    seg_n = 7'b1000110;
            4'hD:    seg_n = 7'b0100001;
            4'hE:    seg_n = 7'b0000110;
            default: seg_n = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/alu_accumulator.sv
// Registered accumulator around the 4-bit ALU op set. Operand B is always
// acc[3:0], so results chain. Op 111 runs a 4-cycle shift-add multiply.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | in_ready=1; single-cycle ops complete on the accept edge
//   ST_MUL  | busy=1; one shift-add iteration per cycle, cnt 0..3
//
module alu_accumulator
    import alu_accum_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [A_W-1:0]       a,
    input  logic                 clear,
    output logic [ACC_W-1:0]     acc,
    output logic                 out_valid,
    output logic                 busy,
    output logic [6:0]           hex_lo,
    output logic [6:0]           hex_hi
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic [A_W-1:0]     mcand_q, mcand_d;
    logic [A_W-1:0]     mplier_q, mplier_d;
    logic [ACC_W-1:0]   prod_q, prod_d;
    logic [1:0]         cnt_q, cnt_d;

    logic [A_W-1:0]     opb;
    logic [A_W:0]       sum5;
    logic [ACC_W-1:0]   op_res;
    logic [ACC_W-1:0]   mul_add;
    logic [ACC_W-1:0]   prod_next;

    assign opb  = acc_q[A_W-1:0];
    assign sum5 = {1'b0, a} + {1'b0, opb};

    // Single-cycle op mux; B is the accumulator low nibble at accept time.
    always_comb begin
        op_res = '0;
        case (op_e'(op))
            OP_ADD5:    op_res = {3'b000, sum5};
            OP_ADD:     op_res = {3'b000, sum5};
            OP_XOR_OR:  op_res = {a ^ opb, a | opb};
            OP_ANY:     op_res = (|{a, opb}) ? 8'h81 : 8'h00;
            OP_ALL:     op_res = (&{a, opb}) ? 8'h7E : 8'h00;
            OP_INV_CAT: op_res = {~a, opb};
            OP_SHL:     op_res = a[3] ? 8'h00 : ({4'b0000, opb} << a[2:0]);
            default:    op_res = '0;
        endcase
    end

    // One shift-add step: add multiplicand << cnt when multiplier bit cnt is set.
    always_comb begin
        mul_add   = mplier_q[cnt_q] ? ({4'b0000, mcand_q} << cnt_q) : 8'h00;
        prod_next = prod_q + mul_add;
    end

    // Next-state logic; clear has priority over any operation in both states.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    acc_d = '0;
                end else if (in_valid && in_ready_q) begin
                    if (op_e'(op) == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = opb;
                        prod_d   = '0;
                        cnt_d    = 2'd0;
                        state_d  = ST_MUL;
                    end else begin
                        acc_d       = op_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (clear) begin
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    prod_d = prod_next;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        acc_d       = prod_next;
                        out_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake flags are registered from the next state so they line up
        // with the state they describe.
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_MUL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
        end
    end

    assign acc       = acc_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;

    seg7_decoder u_hex_lo (.nibble(acc_q[3:0]), .seg_n(hex_lo));
    seg7_decoder u_hex_hi (.nibble(acc_q[7:4]), .seg_n(hex_hi));

endmodule
